// File: rtl/vxe_txn_decoder.sv
// vxe_txn_decoder: slices a packed response vector into transaction fields and registers a qualified copy
module vxe_txn_decoder #(
  parameter logic [1:0] CLNT_CU   = 2'b00,
  parameter logic [1:0] CLNT_VPU0 = 2'b01,
  parameter logic [1:0] CLNT_VPU1 = 2'b10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_vld,
  input  logic [8:0] i_res_vec_txn,
  output logic [5:0] o_txnid,
  output logic       o_rnw,
  output logic [1:0] o_err,
  output logic [1:0] o_client_id,
  output logic [2:0] o_thread_id,
  output logic       o_argument,
  output logic       o_bad_client,
  output logic       o_r_vld,
  output logic [1:0] o_r_client_id,
  output logic [2:0] o_r_thread_id,
  output logic       o_r_argument,
  output logic       o_r_rnw,
  output logic [1:0] o_r_err,
  output logic       o_r_bad_client
);
  logic       r_vld_d, r_vld_q;
  logic [1:0] r_client_id_d, r_client_id_q;
  logic [2:0] r_thread_id_d, r_thread_id_q;
  logic       r_argument_d, r_argument_q;
  logic       r_rnw_d, r_rnw_q;
  logic [1:0] r_err_d, r_err_q;
  logic       r_bad_client_d, r_bad_client_q;
  // pure bit-slice decode of the live vector; thread/argument decoded for every client, CU included
  always_comb begin
    o_txnid      = i_res_vec_txn[8:3];
    o_rnw        = i_res_vec_txn[2];
    o_err        = i_res_vec_txn[1:0];
    o_client_id  = o_txnid[5:4];
    o_thread_id  = o_txnid[3:1];
    o_argument   = o_txnid[0];
    o_bad_client = (o_client_id != CLNT_CU) && (o_client_id != CLNT_VPU0) && (o_client_id != CLNT_VPU1);
  end
  // capture on valid, otherwise hold fields and drop the valid flag
  always_comb begin
    r_vld_d        = i_vld;
    r_client_id_d  = i_vld ? o_client_id  : r_client_id_q;
    r_thread_id_d  = i_vld ? o_thread_id  : r_thread_id_q;
    r_argument_d   = i_vld ? o_argument   : r_argument_q;
    r_rnw_d        = i_vld ? o_rnw        : r_rnw_q;
    r_err_d        = i_vld ? o_err        : r_err_q;
    r_bad_client_d = i_vld ? o_bad_client : r_bad_client_q;
  end
  // output register; async reset discards any captured vector immediately
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_vld_q        <= 1'b0;
      r_client_id_q  <= 2'b00;
      r_thread_id_q  <= 3'b000;
      r_argument_q   <= 1'b0;
      r_rnw_q        <= 1'b0;
      r_err_q        <= 2'b00;
      r_bad_client_q <= 1'b0;
    end else begin
      r_vld_q        <= r_vld_d;
      r_client_id_q  <= r_client_id_d;
      r_thread_id_q  <= r_thread_id_d;
      r_argument_q   <= r_argument_d;
      r_rnw_q        <= r_rnw_d;
      r_err_q        <= r_err_d;
      r_bad_client_q <= r_bad_client_d;
    end
  end
  assign o_r_vld        = r_vld_q;
  assign o_r_client_id  = r_client_id_q;
  assign o_r_thread_id  = r_thread_id_q;
  assign o_r_argument   = r_argument_q;
  assign o_r_rnw        = r_rnw_q;
  assign o_r_err        = r_err_q;
  assign o_r_bad_client = r_bad_client_q;
endmodule

// File: tb/tb_vxe_txn_decoder.sv
// tb_vxe_txn_decoder: scoreboard bench with an arithmetic reference model of the field layout
module tb_vxe_txn_decoder;
  typedef struct packed {
    logic [1:0] c;
    logic [2:0] t;
    logic       a;
    logic       r;
    logic [1:0] e;
    logic       b;
  } rec_t;
  logic       clk = 0;
  logic       nrst = 0;
  logic       i_vld = 0;
  logic [8:0] i_res_vec_txn = '0;
  logic [5:0] o_txnid;
  logic       o_rnw;
  logic [1:0] o_err;
  logic [1:0] o_client_id;
  logic [2:0] o_thread_id;
  logic       o_argument;
  logic       o_bad_client;
  logic       o_r_vld;
  logic [1:0] o_r_client_id;
  logic [2:0] o_r_thread_id;
  logic       o_r_argument;
  logic       o_r_rnw;
  logic [1:0] o_r_err;
  logic       o_r_bad_client;
  int total = 0;
  int bad = 0;
  rec_t exp_q[$];
  rec_t last = '0;
  vxe_txn_decoder dut (
    .clk(clk), .nrst(nrst), .i_vld(i_vld), .i_res_vec_txn(i_res_vec_txn),
    .o_txnid(o_txnid), .o_rnw(o_rnw), .o_err(o_err), .o_client_id(o_client_id),
    .o_thread_id(o_thread_id), .o_argument(o_argument), .o_bad_client(o_bad_client),
    .o_r_vld(o_r_vld), .o_r_client_id(o_r_client_id), .o_r_thread_id(o_r_thread_id),
    .o_r_argument(o_r_argument), .o_r_rnw(o_r_rnw), .o_r_err(o_r_err),
    .o_r_bad_client(o_r_bad_client)
  );
  always #5 clk = ~clk;
  function automatic rec_t model(int v);
    rec_t m;
    int txn;
    txn = v / 8;
    m.c = 2'(txn / 16);
    m.t = 3'((txn / 2) % 8);
    m.a = 1'(txn % 2);
    m.r = 1'((v / 4) % 2);
    m.e = 2'(v % 4);
    m.b = (txn / 16) == 3;
    return m;
  endfunction
  function automatic rec_t comb_act();
    return {o_client_id, o_thread_id, o_argument, o_rnw, o_err, o_bad_client};
  endfunction
  function automatic rec_t reg_act();
    return {o_r_client_id, o_r_thread_id, o_r_argument, o_r_rnw, o_r_err, o_r_bad_client};
  endfunction
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (vec=%h t=%0t)", name, act, exp, i_res_vec_txn, $time);
    end
  endtask
  task automatic send(logic v, logic [8:0] d);
    i_vld = v;
    i_res_vec_txn = d;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) if (nrst && i_vld) exp_q.push_back(model(int'(i_res_vec_txn)));
  always @(negedge clk) begin
    if (nrst) begin
      check("comb_txnid", 16'(o_txnid), 16'(int'(i_res_vec_txn) / 8));
      check("comb_fields", 16'(comb_act()), 16'(model(int'(i_res_vec_txn))));
      if (o_r_vld) begin
        if (exp_q.size() == 0) check("unexpected_r_vld", 16'(1), 16'(0));
        else begin
          last = exp_q.pop_front();
          check("reg_fields", 16'(reg_act()), 16'(last));
        end
      end else begin
        check("hold_no_pending", 16'(exp_q.size()), 16'(0));
        check("hold_fields", 16'(reg_act()), 16'(last));
      end
    end
  end
  initial begin
    #3;
    check("reset_vld", 16'(o_r_vld), 16'(0));
    check("reset_fields", 16'(reg_act()), 16'(0));
    check("reset_comb", 16'(comb_act()), 16'(model(0)));
    #9 nrst = 1;
    @(posedge clk);
    #1;
    send(1, 9'h0BC);
    send(1, 9'h001);
    send(1, 9'h177);
    send(1, 9'h180);
    send(0, 9'h0BC);
    send(0, 9'h0AA);
    send(1, 9'h0BC);
    send(1, 9'h001);
    send(1, 9'h177);
    send(0, 9'h055);
    send(0, 9'h1FF);
    for (int i = 0; i < 300; i++) send(1'($urandom_range(0, 2) != 0), 9'($urandom));
    for (int k = 0; k < 3; k++) begin
      send(1, 9'($urandom));
      send(1, 9'($urandom));
      #1 nrst = 0;
      i_res_vec_txn = 9'h0BC;
      #1;
      check("async_reset_vld", 16'(o_r_vld), 16'(0));
      check("async_reset_fields", 16'(reg_act()), 16'(0));
      check("reset_comb_track", 16'(comb_act()), 16'(model(9'h0BC)));
      exp_q.delete();
      last = '0;
      #1 nrst = 1;
      send(0, 9'($urandom));
      send(0, 9'($urandom));
      for (int i = 0; i < 100; i++) send(1'($urandom_range(0, 1)), 9'($urandom));
    end
    send(0, 9'h000);
    send(0, 9'h000);
    check("drain_empty", 16'(exp_q.size()), 16'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
